// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter sequencer: state encodings, widths and
// small helpers used by the FSM.
package counter_ctrl_pkg;

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned HOLD_W = 8;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_HOLD      = 3'd1,
        ST_ARMED     = 3'd2,
        ST_RUN       = 3'd3,
        ST_PAUSED    = 3'd4,
        ST_DONE      = 3'd5
    } ctrl_state_t;

    // Recovery target for the unused codes 6/7.
    localparam ctrl_state_t ST_ILLEGAL_DEFAULT = ST_WAIT_LOCK;

    // The counter is held in reset while waiting for lock and during the hold window.
    function automatic logic holds_counter(input ctrl_state_t s);
        return (s == ST_WAIT_LOCK) || (s == ST_HOLD);
    endfunction

    function automatic logic counts(input ctrl_state_t s);
        return (s == ST_RUN);
    endfunction

endpackage

// File: rtl/counter_ctrl_sync.sv
// Multi-stage synchroniser for a single asynchronous level (LOCKED), with a
// synchronous clear of the whole chain.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/counter_ctrl.sv
// Sequencer for the external 32-bit counter: waits for clock lock, holds the
// counter in reset, then gates CE on commands and stops exactly at LIMIT.
module counter_ctrl #(
    parameter int unsigned RST_CYCLES  = 20,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        R,
    input  logic        LOCKED,
    input  logic        START,
    input  logic        STOP,
    input  logic        CLEAR,
    input  logic [31:0] LIMIT,
    input  logic [31:0] Q,
    output logic        CNT_R,
    output logic        CNT_CE,
    output logic        BUSY,
    output logic        DONE,
    output logic [2:0]  STATE
);

    import counter_ctrl_pkg::*;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_CYCLES - 1);

    ctrl_state_t       r_state;
    ctrl_state_t       w_next;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_next;
    logic [CNT_W-1:0]  r_lim;
    logic              r_cnt_r;
    logic              r_cnt_ce;
    logic              w_lk;
    logic              w_term;
    logic              w_load_lim;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .i_clk(CLK),
        .i_rst(R),
        .i_d  (LOCKED),
        .o_q  (w_lk)
    );

    // Q is one cycle behind CE, so seeing lim-1 with CE still high means the
    // edge that drops CE is the same edge that lands Q on lim.
    assign w_term = (r_lim != '0) && (Q == (r_lim - 32'd1)) && r_cnt_ce;

    always_comb begin
        w_next      = r_state;
        w_hold_next = r_hold;
        w_load_lim  = 1'b0;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_lk) begin
                    w_next      = ST_HOLD;
                    w_hold_next = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (!w_lk) begin
                    w_next = ST_WAIT_LOCK;
                end else if (r_hold == '0) begin
                    w_next = ST_ARMED;
                end else begin
                    w_hold_next = r_hold - 1'b1;
                end
            end
            ST_ARMED: begin
                if (!w_lk) begin
                    w_next = ST_WAIT_LOCK;
                end else if (CLEAR) begin
                    w_next      = ST_HOLD;
                    w_hold_next = HOLD_LOAD;
                end else if (START && !STOP) begin
                    w_next     = ST_RUN;
                    w_load_lim = 1'b1;
                end
            end
            ST_RUN: begin
                if (!w_lk) begin
                    w_next = ST_WAIT_LOCK;
                end else if (CLEAR) begin
                    w_next      = ST_HOLD;
                    w_hold_next = HOLD_LOAD;
                end else if (w_term) begin
                    w_next = ST_DONE;
                end else if (STOP) begin
                    w_next = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (!w_lk) begin
                    w_next = ST_WAIT_LOCK;
                end else if (CLEAR) begin
                    w_next      = ST_HOLD;
                    w_hold_next = HOLD_LOAD;
                end else if (START && !STOP) begin
                    w_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (!w_lk) begin
                    w_next = ST_WAIT_LOCK;
                end else if (CLEAR) begin
                    w_next      = ST_HOLD;
                    w_hold_next = HOLD_LOAD;
                end
            end
            default: begin
                w_next = ST_ILLEGAL_DEFAULT;
            end
        endcase
    end

    // R and CE follow the next state so they change on the same edge as STATE.
    always_ff @(posedge CLK) begin
        if (R) begin
            r_state  <= ST_WAIT_LOCK;
            r_hold   <= '0;
            r_lim    <= '0;
            r_cnt_r  <= 1'b1;
            r_cnt_ce <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_hold   <= w_hold_next;
            r_cnt_r  <= holds_counter(w_next);
            r_cnt_ce <= counts(w_next);
            if (w_load_lim) begin
                r_lim <= LIMIT;
            end
        end
    end

    assign CNT_R  = r_cnt_r;
    assign CNT_CE = r_cnt_ce;
    assign BUSY   = (r_state == ST_RUN);
    assign DONE   = (r_state == ST_DONE);
    assign STATE  = r_state;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench: counter_ctrl driving a behavioural 32-bit counter, with
// LOCKED driven directly in place of the clock wizard.
module tb_counter_ctrl;

    logic        CLK = 1'b0;
    logic        R;
    logic        LOCKED;
    logic        START;
    logic        STOP;
    logic        CLEAR;
    logic [31:0] LIMIT;
    logic [31:0] Q = '0;
    logic        CNT_R;
    logic        CNT_CE;
    logic        BUSY;
    logic        DONE;
    logic [2:0]  STATE;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned ce_edges = 0;

    always #5 CLK = ~CLK;

    counter_ctrl #(
        .RST_CYCLES (20),
        .SYNC_STAGES(2)
    ) u_dut (
        .CLK   (CLK),
        .R     (R),
        .LOCKED(LOCKED),
        .START (START),
        .STOP  (STOP),
        .CLEAR (CLEAR),
        .LIMIT (LIMIT),
        .Q     (Q),
        .CNT_R (CNT_R),
        .CNT_CE(CNT_CE),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .STATE (STATE)
    );

    // Counter being sequenced: synchronous R, increment on CE.
    always @(posedge CLK) begin
        if (CNT_R)
            Q <= '0;
        else if (CNT_CE)
            Q <= Q + 32'd1;
        if (CNT_CE)
            ce_edges <= ce_edges + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int unsigned bound, input string tag);
        for (int unsigned i = 0; i < bound && STATE != s; i++) tick(1);
        check(tag, {29'd0, STATE}, {29'd0, s});
    endtask

    task automatic wait_q(input logic [31:0] v, input int unsigned bound, input string tag);
        for (int unsigned i = 0; i < bound && Q != v; i++) tick(1);
        check(tag, Q, v);
    endtask

    // Counts cycles spent in HOLD with CNT_R high, then expects ARMED with Q=0.
    task automatic count_hold(input string tag);
        int unsigned n = 0;
        wait_state(3'd1, 10, {tag, "_enter_hold"});
        for (int unsigned i = 0; i < 300 && STATE == 3'd1; i++) begin
            if (CNT_R) n++;
            tick(1);
        end
        check({tag, "_hold_len"}, n, 32'd20);
        check({tag, "_armed"}, {29'd0, STATE}, 32'd2);
        check({tag, "_cnt_r_low"}, {31'd0, CNT_R}, 32'd0);
        tick(1);
        check({tag, "_q_zero"}, Q, 32'd0);
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick(1);
        START = 1'b0;
    endtask

    task automatic do_clear(input string tag);
        CLEAR = 1'b1;
        tick(1);
        CLEAR = 1'b0;
        count_hold(tag);
    endtask

    initial begin
        int unsigned ce_base;
        R = 1'b1; LOCKED = 1'b0; START = 1'b0; STOP = 1'b0; CLEAR = 1'b0; LIMIT = '0;

        // Power-up
        tick(10);
        check("rst_state", {29'd0, STATE}, 32'd0);
        check("rst_cnt_r", {31'd0, CNT_R}, 32'd1);
        check("rst_cnt_ce", {31'd0, CNT_CE}, 32'd0);
        check("rst_busy_done", {30'd0, BUSY, DONE}, 32'd0);
        R = 1'b0;
        tick(5);
        check("nolock_state", {29'd0, STATE}, 32'd0);
        check("nolock_cnt_r", {31'd0, CNT_R}, 32'd1);
        LOCKED = 1'b1;
        count_hold("lock");

        // LIMIT=1000 run to DONE
        LIMIT = 32'd1000;
        ce_base = ce_edges;
        pulse_start();
        check("run_busy", {31'd0, BUSY}, 32'd1);
        wait_state(3'd5, 1100, "lim1000_done_state");
        check("lim1000_ce_edges", ce_edges - ce_base, 32'd1000);
        check("lim1000_q", Q, 32'h3E8);
        check("lim1000_done", {31'd0, DONE}, 32'd1);
        tick(50);
        check("lim1000_q_stable", Q, 32'h3E8);
        check("lim1000_ce_off", {31'd0, CNT_CE}, 32'd0);

        // CLEAR from DONE
        do_clear("clear_done");

        // Free-run, pause at 300, resume
        LIMIT = 32'd0;
        pulse_start();
        wait_q(32'd299, 400, "free_reach_299");
        STOP = 1'b1;
        tick(1);
        STOP = 1'b0;
        check("pause_q", Q, 32'd300);
        check("pause_state", {29'd0, STATE}, 32'd4);
        tick(10);
        check("pause_q_held", Q, 32'd300);
        pulse_start();
        check("resume_state", {29'd0, STATE}, 32'd3);
        tick(1);
        check("resume_q", Q, 32'd301);
        STOP = 1'b1;
        tick(1);
        STOP = 1'b0;
        do_clear("clear_paused");

        // START+STOP together in ARMED
        START = 1'b1; STOP = 1'b1;
        tick(3);
        check("startstop_state", {29'd0, STATE}, 32'd2);
        check("startstop_ce", {31'd0, CNT_CE}, 32'd0);
        START = 1'b0; STOP = 1'b0;

        // STOP on the terminal cycle, LIMIT=10
        LIMIT = 32'd10;
        pulse_start();
        wait_q(32'd9, 20, "lim10_reach_9");
        STOP = 1'b1;
        tick(1);
        STOP = 1'b0;
        check("lim10_stop_done", {29'd0, STATE}, 32'd5);
        check("lim10_q", Q, 32'd10);
        tick(5);
        check("lim10_q_stable", Q, 32'd10);
        do_clear("clear_lim10");

        // LIMIT=1: one edge to DONE
        LIMIT = 32'd1;
        pulse_start();
        check("lim1_run_q0", Q, 32'd0);
        tick(1);
        check("lim1_done_state", {29'd0, STATE}, 32'd5);
        check("lim1_q", Q, 32'd1);
        do_clear("clear_lim1");

        // Lock loss mid-RUN
        LIMIT = 32'd0;
        pulse_start();
        wait_q(32'd500, 600, "free_reach_500");
        LOCKED = 1'b0;
        wait_state(3'd0, 8, "lockloss_state");
        check("lockloss_ce", {31'd0, CNT_CE}, 32'd0);
        check("lockloss_cnt_r", {31'd0, CNT_R}, 32'd1);
        check("lockloss_busy", {31'd0, BUSY}, 32'd0);
        tick(1);
        check("lockloss_q", Q, 32'd0);
        tick(5);
        LOCKED = 1'b1;
        count_hold("relock");

        // R mid-RUN
        pulse_start();
        tick(20);
        R = 1'b1;
        tick(1);
        check("rrun_state", {29'd0, STATE}, 32'd0);
        check("rrun_cnt_r", {31'd0, CNT_R}, 32'd1);
        check("rrun_cnt_ce", {31'd0, CNT_CE}, 32'd0);
        check("rrun_busy_done", {30'd0, BUSY, DONE}, 32'd0);
        R = 1'b0;
        count_hold("after_r");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
